// File: rtl/ecg_fmap_bank_array.sv
// Multi-bank feature-map buffer: NUM_BANKS simple-dual-port RAM banks with a streaming preload port.
// Optional build macro ECG_FMAP_WR_BYPASS_EN selects write-first forwarding on same-address read/write.
module ecg_fmap_bank_array #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 1024,
  parameter int NUM_BANKS  = 4,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int BANK_WIDTH = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  csen,
  input  logic                  rd_en,
  input  logic [BANK_WIDTH-1:0] rd_bank,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  wr_en,
  input  logic [BANK_WIDTH-1:0] wr_bank,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  ld_start,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_ready,
  output logic                  ld_done,
  output logic                  busy
);

  localparam int                CNT_W    = BANK_WIDTH + ADDR_WIDTH;
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NUM_BANKS * DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_LOAD = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] ld_cnt;
  logic             in_load;
  logic             ld_fire;
  logic             ld_last;
  logic             cmp_wr;
  logic             rd_acc;

  assign in_load  = (state == S_LOAD);
  assign busy     = in_load;
  assign ld_ready = in_load;
  // A restart pulse wins over any beat presented in the same cycle.
  assign ld_fire  = in_load & ld_valid & ~ld_start;
  assign ld_last  = ld_fire & (ld_cnt == LAST_CNT);
  assign cmp_wr   = wr_en & csen & ~in_load;
  assign rd_acc   = rd_en & csen & ~in_load;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      ld_cnt  <= '0;
      ld_done <= 1'b0;
    end else begin
      ld_done <= ld_last;
      if (ld_start) begin
        state  <= S_LOAD;
        ld_cnt <= '0;
      end else if (ld_last) begin
        state  <= S_IDLE;
        ld_cnt <= '0;
      end else if (ld_fire) begin
        ld_cnt <= ld_cnt + CNT_ONE;
      end
    end
  end

  // Shared write port: preload and compute writes are mutually exclusive via in_load.
  logic                  mem_we;
  logic [BANK_WIDTH-1:0] mem_wbank;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    mem_we    = ld_fire | cmp_wr;
    mem_wbank = wr_bank;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (in_load) begin
      mem_wbank = ld_cnt[CNT_W-1:ADDR_WIDTH];
      mem_waddr = ld_cnt[ADDR_WIDTH-1:0];
      mem_wdata = ld_data;
    end
  end

  logic [DATA_WIDTH-1:0] bank_q [NUM_BANKS];

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] q;

    // NOTE: RAM array and its read register carry no reset so the bank maps onto block RAM.
    always_ff @(posedge clk) begin
      if (mem_we && (mem_wbank == BANK_WIDTH'(b)))
        mem[mem_waddr] <= mem_wdata;
      if (rd_acc && (rd_bank == BANK_WIDTH'(b)))
        q <= mem[rd_addr];
    end

    assign bank_q[b] = q;
  end

  logic [BANK_WIDTH-1:0] rd_sel;

`ifdef ECG_FMAP_WR_BYPASS_EN
  logic                  byp_hit;
  logic [DATA_WIDTH-1:0] byp_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_sel   <= '0;
      byp_hit  <= 1'b0;
      byp_data <= '0;
    end else begin
      rd_valid <= rd_acc;
      rd_sel   <= rd_bank;
      byp_hit  <= rd_acc & cmp_wr & (rd_bank == wr_bank) & (rd_addr == wr_addr);
      byp_data <= wr_data;
    end
  end

  assign rd_data = !rd_valid ? '0 : (byp_hit ? byp_data : bank_q[rd_sel]);
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_sel   <= '0;
    end else begin
      rd_valid <= rd_acc;
      rd_sel   <= rd_bank;
    end
  end

  // Unaccepted reads present zero; the RAM read register itself keeps stale data.
  assign rd_data = rd_valid ? bank_q[rd_sel] : '0;
`endif

endmodule

// File: tb/tb_ecg_fmap_bank_array.sv
// Directed bench for ecg_fmap_bank_array (4 banks x 16 words x 8 bits): preload, compute access,
// restart, toggled valid and asynchronous reset during a load.
module tb_ecg_fmap_bank_array;

  logic       clk;
  logic       rst_n;
  logic       csen;
  logic       rd_en;
  logic [1:0] rd_bank;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       wr_en;
  logic [1:0] wr_bank;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       ld_start;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_ready;
  logic       ld_done;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int done_seen = 0;

`ifdef ECG_FMAP_WR_BYPASS_EN
  localparam logic [7:0] BYP_EXP = 8'h3C;
`else
  localparam logic [7:0] BYP_EXP = 8'h11;
`endif

  ecg_fmap_bank_array #(
    .DATA_WIDTH(8),
    .DEPTH     (16),
    .NUM_BANKS (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .csen     (csen),
    .rd_en    (rd_en),
    .rd_bank  (rd_bank),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .wr_en    (wr_en),
    .wr_bank  (wr_bank),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .ld_start (ld_start),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .ld_done  (ld_done),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (ld_done) done_seen++;

  typedef struct {
    logic       csen;
    logic       rd_en;
    logic       wr_en;
    logic [1:0] rd_bank;
    logic [1:0] wr_bank;
    logic [3:0] rd_addr;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] exp_data;
    logic       exp_valid;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    csen = 0; rd_en = 0; wr_en = 0; rd_bank = 0; rd_addr = 0;
    wr_bank = 0; wr_addr = 0; wr_data = 0;
    ld_start = 0; ld_valid = 0; ld_data = 0;
  endtask

  task automatic rd_chk(input string name, input logic [1:0] b, input logic [3:0] a,
                        input logic [7:0] exp);
    csen = 1; rd_en = 1; rd_bank = b; rd_addr = a;
    step();
    rd_en = 0; csen = 0;
    check({name, "_data"}, {24'd0, rd_data}, {24'd0, exp});
    check({name, "_valid"}, {31'd0, rd_valid}, 32'd1);
  endtask

  task automatic start_load();
    ld_start = 1; ld_valid = 0;
    step();
    ld_start = 0;
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_ready", {31'd0, ld_ready}, 32'd1);
  endtask

  // Streams 64 accepted beats of base+n; one cycle also attempts a compute read/write to bank 0 addr 5.
  task automatic load_stream(input logic [7:0] base, input bit toggle);
    int acc;
    int d0;
    acc = 0;
    d0  = done_seen;
    for (int cyc = 0; acc < 64; cyc++) begin
      ld_valid = toggle ? ((cyc % 2) == 0) : 1'b1;
      ld_data  = 8'(int'(base) + acc);
      if (cyc == 12) begin
        csen = 1; rd_en = 1; wr_en = 1;
        rd_bank = 0; rd_addr = 5; wr_bank = 0; wr_addr = 5; wr_data = 8'hEE;
      end
      check("ld_ready_in_load", {31'd0, ld_ready}, 32'd1);
      check("no_early_done", {31'd0, ld_done}, 32'd0);
      if (ld_valid) acc++;
      step();
      if (cyc == 12) begin
        check("load_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("load_rd_data", {24'd0, rd_data}, 32'd0);
        csen = 0; rd_en = 0; wr_en = 0;
      end
    end
    ld_valid = 0;
    check("ld_done_after_final", {31'd0, ld_done}, 32'd1);
    check("busy_fall", {31'd0, busy}, 32'd0);
    check("ready_fall", {31'd0, ld_ready}, 32'd0);
    step();
    check("ld_done_one_cycle", {31'd0, ld_done}, 32'd0);
    check("ld_done_count", done_seen - d0, 32'd1);
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    #3;
    check("rst_rd_data", {24'd0, rd_data}, 32'd0);
    check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("rst_ld_ready", {31'd0, ld_ready}, 32'd0);
    check("rst_ld_done", {31'd0, ld_done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1;
    step();
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Toggled-valid preload, restarted after 20 beats; restart-cycle beat is dropped.
    start_load();
    for (int cyc = 0, acc = 0; acc < 20; cyc++) begin
      ld_valid = ((cyc % 2) == 0);
      ld_data  = 8'(8'h40 + acc);
      if (ld_valid) acc++;
      step();
    end
    ld_start = 1; ld_valid = 1; ld_data = 8'h77;
    step();
    ld_start = 0; ld_valid = 0;
    check("restart_busy", {31'd0, busy}, 32'd1);
    load_stream(8'h80, 1'b1);
    rd_chk("restart_b0a0", 2'd0, 4'd0, 8'h80);
    rd_chk("restart_b0a5", 2'd0, 4'd5, 8'h85);
    rd_chk("restart_b1a3", 2'd1, 4'd3, 8'h93);
    rd_chk("restart_b2a4", 2'd2, 4'd4, 8'hA4);
    rd_chk("restart_b3a15", 2'd3, 4'd15, 8'hBF);

    // Asynchronous reset during beat 30 of a load.
    start_load();
    for (int i = 0; i < 30; i++) begin
      ld_valid = 1; ld_data = 8'(i);
      step();
    end
    ld_valid = 1; ld_data = 8'd30;
    #2 rst_n = 0;
    #1;
    check("midrst_rd_data", {24'd0, rd_data}, 32'd0);
    check("midrst_rd_valid", {31'd0, rd_valid}, 32'd0);
    check("midrst_ld_ready", {31'd0, ld_ready}, 32'd0);
    check("midrst_ld_done", {31'd0, ld_done}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1;
    begin
      int d0;
      d0 = done_seen;
      for (int i = 0; i < 4; i++) begin
        step();
        check("postrst_no_done", {31'd0, ld_done}, 32'd0);
        check("postrst_idle", {31'd0, busy}, 32'd0);
      end
      check("postrst_done_count", done_seen - d0, 32'd0);
    end

    // Full contiguous preload of 16*b+a.
    start_load();
    load_stream(8'h00, 1'b0);
    rd_chk("load_b0a5_survives", 2'd0, 4'd5, 8'h05);
    rd_chk("load_b2a9", 2'd2, 4'd9, 8'h29);

    vecs[0]  = '{1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 4'd0,  4'd0, 8'h00, 8'h00, 1'b1};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 2'd3, 2'd0, 4'd15, 4'd0, 8'h00, 8'h3F, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 2'd1, 2'd0, 4'd5,  4'd0, 8'h00, 8'h15, 1'b1};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 2'd0, 2'd2, 4'd0,  4'd7, 8'hA5, 8'h00, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 2'd2, 2'd0, 4'd7,  4'd0, 8'h00, 8'hA5, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 2'd0, 2'd2, 4'd0,  4'd7, 8'h5A, 8'h00, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 2'd2, 2'd0, 4'd7,  4'd0, 8'h00, 8'hA5, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 2'd0, 2'd0, 4'd1,  4'd0, 8'h00, 8'h00, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 2'd0, 2'd1, 4'd0,  4'd3, 8'h11, 8'h00, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 2'd1, 2'd1, 4'd3,  4'd3, 8'h3C, BYP_EXP, 1'b1};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 2'd1, 2'd0, 4'd3,  4'd0, 8'h00, 8'h3C, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 2'd0, 2'd0, 4'd3,  4'd2, 8'hFF, 8'h03, 1'b1};
    vecs[12] = '{1'b1, 1'b1, 1'b0, 2'd0, 2'd0, 4'd2,  4'd0, 8'h00, 8'hFF, 1'b1};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 2'd2, 2'd3, 4'd2,  4'd2, 8'hC3, 8'h22, 1'b1};
    vecs[14] = '{1'b1, 1'b1, 1'b0, 2'd3, 2'd0, 4'd2,  4'd0, 8'h00, 8'hC3, 1'b1};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 2'd2, 2'd0, 4'd2,  4'd0, 8'h00, 8'h22, 1'b1};

    for (int i = 0; i < 16; i++) begin
      csen = vecs[i].csen; rd_en = vecs[i].rd_en; wr_en = vecs[i].wr_en;
      rd_bank = vecs[i].rd_bank; wr_bank = vecs[i].wr_bank;
      rd_addr = vecs[i].rd_addr; wr_addr = vecs[i].wr_addr; wr_data = vecs[i].wr_data;
      step();
      check($sformatf("vec%0d_data", i), {24'd0, rd_data}, {24'd0, vecs[i].exp_data});
      check($sformatf("vec%0d_valid", i), {31'd0, rd_valid}, {31'd0, vecs[i].exp_valid});
    end
    idle_inputs();
    step();
    check("idle_rd_valid", {31'd0, rd_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
